// File: rtl/chacha_host.sv
// chacha_host: buffers key/nonce/counter bytes from an upstream stream,
// burst-writes them into the chacha core, then reads keystream blocks.
// For multi-block requests the block counter is incremented and rewritten
// before every further block; key and nonce are written only once.
module chacha_host #(
  parameter int KEY_BYTES = 32,
  parameter int NNC_BYTES = 12,
  parameter int CTR_BYTES = 4,
  parameter int BLK_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] blk_count,
  output logic       busy,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  output logic       ks_valid,
  output logic [7:0] ks_data,
  output logic       ks_last,
  output logic       ctr_wrap,
  output logic       cc_wr_key,
  output logic       cc_wr_nnc,
  output logic       cc_wr_ctr,
  output logic [7:0] cc_din,
  input  logic       cc_blk_ready,
  output logic       cc_rd_blk,
  input  logic [7:0] cc_dout
);

  localparam int KN_BYTES  = KEY_BYTES + NNC_BYTES;
  localparam int CFG_BYTES = KN_BYTES + CTR_BYTES;
  localparam int IDX_W     = $clog2(CFG_BYTES);
  localparam int CNT_W     = $clog2(BLK_BYTES + 1);
  localparam int CTR_W     = 8 * CTR_BYTES;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WKEY, S_WNNC, S_WCTR, S_WAIT, S_READ
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] ctr_sel;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       rem_q;
  logic [CTR_W-1:0] ctr_q;
  logic [7:0]       kn_q [KN_BYTES];
  logic             rd_q;
  logic             ks_valid_q;
  logic             ks_last_q;
  logic             wrap_q;
  logic [7:0]       ks_data_q;
  logic             burst_last;
  logic             cap;
  logic             cap_last;
  logic             start_ok;

  assign start_ok = start && (blk_count != 8'd0);
  // Capture cycles are the 64 READ cycles after the rd_blk cycle (cnt 1..64).
  assign cap      = (state_q == S_READ) && (cnt_q != '0);
  assign cap_last = cap && (cnt_q == CNT_W'(BLK_BYTES));
  assign ctr_sel  = idx_q - IDX_W'(KN_BYTES);

  assign busy      = (state_q != S_IDLE);
  assign cc_rd_blk = rd_q;
  assign ks_valid  = ks_valid_q;
  assign ks_data   = ks_data_q;
  assign ks_last   = ks_last_q;
  assign ctr_wrap  = wrap_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and the core-side write port, decoded from state and byte index.
  always_comb begin
    state_d    = state_q;
    cfg_ready  = 1'b0;
    cc_wr_key  = 1'b0;
    cc_wr_nnc  = 1'b0;
    cc_wr_ctr  = 1'b0;
    cc_din     = 8'd0;
    burst_last = 1'b0;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_LOAD;
      S_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid && (idx_q == IDX_W'(CFG_BYTES - 1))) state_d = S_WKEY;
      end
      S_WKEY: begin
        cc_wr_key  = (idx_q == '0);
        cc_din     = kn_q[idx_q];
        burst_last = (idx_q == IDX_W'(KEY_BYTES - 1));
        if (burst_last) state_d = S_WNNC;
      end
      S_WNNC: begin
        cc_wr_nnc  = (idx_q == '0);
        cc_din     = kn_q[KEY_BYTES + int'(idx_q)];
        burst_last = (idx_q == IDX_W'(NNC_BYTES - 1));
        if (burst_last) state_d = S_WCTR;
      end
      S_WCTR: begin
        cc_wr_ctr  = (idx_q == '0);
        cc_din     = ctr_q[{idx_q, 3'b000} +: 8];
        burst_last = (idx_q == IDX_W'(CTR_BYTES - 1));
        if (burst_last) state_d = S_WAIT;
      end
      S_WAIT: if (cc_blk_ready) state_d = S_READ;
      S_READ: if (cap_last) state_d = (rem_q == 8'd1) ? S_IDLE : S_WCTR;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: config buffer, byte/capture counters, block counter and keystream capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      rem_q      <= 8'd0;
      ctr_q      <= '0;
      rd_q       <= 1'b0;
      ks_valid_q <= 1'b0;
      ks_data_q  <= 8'd0;
      ks_last_q  <= 1'b0;
      wrap_q     <= 1'b0;
      for (int i = 0; i < KN_BYTES; i++) kn_q[i] <= 8'd0;
    end else begin
      rd_q       <= (state_q == S_WAIT) && cc_blk_ready;
      ks_valid_q <= cap;
      ks_data_q  <= cap ? cc_dout : 8'd0;
      ks_last_q  <= cap_last && (rem_q == 8'd1);
      wrap_q     <= cap_last && (rem_q != 8'd1) && (&ctr_q);
      case (state_q)
        S_IDLE: begin
          idx_q <= '0;
          cnt_q <= '0;
          if (start_ok) rem_q <= blk_count;
        end
        S_LOAD: begin
          if (cfg_valid) begin
            if (idx_q < IDX_W'(KN_BYTES)) kn_q[idx_q] <= cfg_data;
            else ctr_q[{ctr_sel, 3'b000} +: 8] <= cfg_data;
            idx_q <= (idx_q == IDX_W'(CFG_BYTES - 1)) ? '0 : idx_q + 1'b1;
          end
        end
        S_WKEY, S_WNNC, S_WCTR: idx_q <= burst_last ? '0 : idx_q + 1'b1;
        S_WAIT: cnt_q <= '0;
        S_READ: begin
          cnt_q <= cnt_q + 1'b1;
          if (cap_last) begin
            cnt_q <= '0;
            rem_q <= rem_q - 8'd1;
            if (rem_q != 8'd1) ctr_q <= ctr_q + CTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_host.sv
// Self-checking bench for chacha_host: a behavioural core model answers
// rd_blk, a monitor logs every core write and keystream byte, and each run
// is compared against the expected byte stream built from the request.
module tb_chacha_host;

  logic       clk = 1'b0;
  logic       rst_n, start, cfg_valid, cfg_ready, busy;
  logic [7:0] blk_count, cfg_data, ks_data, cc_din, cc_dout;
  logic       ks_valid, ks_last, ctr_wrap;
  logic       cc_wr_key, cc_wr_nnc, cc_wr_ctr, cc_blk_ready, cc_rd_blk;

  always #5 clk = ~clk;

  chacha_host dut (
    .clk(clk), .rst_n(rst_n), .start(start), .blk_count(blk_count), .busy(busy),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_last(ks_last), .ctr_wrap(ctr_wrap),
    .cc_wr_key(cc_wr_key), .cc_wr_nnc(cc_wr_nnc), .cc_wr_ctr(cc_wr_ctr), .cc_din(cc_din),
    .cc_blk_ready(cc_blk_ready), .cc_rd_blk(cc_rd_blk), .cc_dout(cc_dout)
  );

  int tests = 0;
  int fails = 0;

  // Stimulus settings (written by the test sequence only).
  logic [7:0]  cfg_bytes [48];
  int          ready_delay = 1;
  int          core_mode = 0;
  logic [31:0] core_seed = 0;
  logic        clr_req = 1'b0;

  // Monitor / core-model state (written by the monitor only).
  int cyc = 0;
  int wr_q[$];
  int ks_q[$];
  int ks_cyc_q[$];
  int rd_cyc_q[$];
  int ctr_end_q[$];
  int viol, wrap_cnt, last_cnt, last_idx, hs_cnt, last_hs_cyc;
  int key_cnt, key_cyc, nnc_cyc, ctr_cyc, wr_left, wr_type, rd_left, blk_idx, ready_cnt;

  function automatic logic [7:0] core_byte(input int mode, input logic [31:0] seed,
                                           input int b, input int k);
    logic [31:0] t;
    t = seed + 32'(b) * 32'd977 + 32'(k) * 32'd131;
    if (mode == 0) return 8'(8'h80 + k);
    return t[10:3];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor and core model, evaluated mid-cycle.
  always @(negedge clk) begin
    logic ready_prev;
    int   nstb;
    if (clr_req) begin
      wr_q.delete(); ks_q.delete(); ks_cyc_q.delete(); rd_cyc_q.delete(); ctr_end_q.delete();
      viol = 0; wrap_cnt = 0; last_cnt = 0; last_idx = -1; hs_cnt = 0; last_hs_cyc = -100;
      key_cnt = 0; key_cyc = -100; nnc_cyc = -100; ctr_cyc = -100;
      wr_left = 0; wr_type = 0; rd_left = 0; blk_idx = 0; ready_cnt = 0;
      cc_blk_ready = 1'b0;
    end
    cyc++;
    ready_prev = cc_blk_ready;
    if (cfg_valid && cfg_ready) begin
      hs_cnt++;
      last_hs_cyc = cyc;
    end
    if (ready_cnt > 0) begin
      ready_cnt--;
      if (ready_cnt == 0) cc_blk_ready = 1'b1;
    end
    nstb = int'(cc_wr_key) + int'(cc_wr_nnc) + int'(cc_wr_ctr);
    if (nstb > 1) viol++;
    if (nstb != 0) begin
      if (wr_left != 0) viol++;
      if (cc_wr_key) begin wr_type = 1; wr_left = 32; key_cnt++; key_cyc = cyc; end
      else if (cc_wr_nnc) begin wr_type = 2; wr_left = 12; nnc_cyc = cyc; end
      else begin wr_type = 3; wr_left = 4; if (ctr_cyc < 0) ctr_cyc = cyc; end
    end
    if (wr_left > 0) begin
      wr_q.push_back(wr_type * 256 + int'(cc_din));
      wr_left--;
      if (wr_left == 0 && wr_type == 3) begin
        ctr_end_q.push_back(cyc);
        ready_cnt = ready_delay;
      end
    end else if (cc_din != 8'd0) viol++;
    if (rd_left > 0) begin
      cc_dout = core_byte(core_mode, core_seed, blk_idx - 1, 64 - rd_left);
      rd_left--;
    end else cc_dout = 8'($urandom);
    if (cc_rd_blk) begin
      if (!ready_prev || rd_left != 0) viol++;
      cc_blk_ready = 1'b0;
      rd_cyc_q.push_back(cyc);
      blk_idx++;
      rd_left = 64;
    end
    if (ks_valid) begin
      ks_q.push_back(int'(ks_data));
      ks_cyc_q.push_back(cyc);
      if (ks_last) begin last_cnt++; last_idx = ks_q.size() - 1; end
    end else if (ks_last) viol++;
    if (ctr_wrap) wrap_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr_req = 1'b1;
    @(negedge clk);
    #1;
    clr_req = 1'b0;
    tick();
  endtask

  task automatic pulse_start(input logic [7:0] n);
    start = 1'b1;
    blk_count = n;
    tick();
    start = 1'b0;
    blk_count = 8'd0;
  endtask

  task automatic feed(input int from, input int to, input int gap);
    int w;
    for (int i = from; i < to; i++) begin
      cfg_valid = 1'b1;
      cfg_data = cfg_bytes[i];
      w = 0;
      @(negedge clk);
      while (!cfg_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!cfg_ready) begin
        check("cfg_ready_wait", longint'(cfg_ready), 1);
        cfg_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      cfg_data = 8'd0;
      if (gap != 0) tick();
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 3000) begin
      tick();
      w++;
    end
    check("busy_end", longint'(busy), 0);
    repeat (3) tick();
  endtask

  // Compare everything the monitor logged against the request's expected behaviour.
  task automatic compare(input string tag, input int n, input int exp_wraps);
    logic [31:0] ctr0, c;
    int exp_wr[$];
    int mism, f0;
    ctr0 = {cfg_bytes[47], cfg_bytes[46], cfg_bytes[45], cfg_bytes[44]};
    f0 = fails;
    for (int i = 0; i < 32; i++) exp_wr.push_back(256 + int'(cfg_bytes[i]));
    for (int i = 32; i < 44; i++) exp_wr.push_back(512 + int'(cfg_bytes[i]));
    for (int b = 0; b < n; b++) begin
      c = ctr0 + 32'(b);
      for (int j = 0; j < 4; j++) exp_wr.push_back(768 + int'(c[8*j +: 8]));
    end
    check({tag, " wr_len"}, wr_q.size(), exp_wr.size());
    mism = 0;
    for (int i = 0; i < exp_wr.size(); i++)
      if (i >= wr_q.size() || wr_q[i] != exp_wr[i]) mism++;
    check({tag, " wr_mismatches"}, mism, 0);
    check({tag, " rd_count"}, rd_cyc_q.size(), n);
    mism = 0;
    for (int b = 0; b < n; b++)
      if (b >= rd_cyc_q.size() || b >= ctr_end_q.size() ||
          rd_cyc_q[b] != ctr_end_q[b] + ready_delay + 1) mism++;
    check({tag, " rd_timing_mismatches"}, mism, 0);
    check({tag, " ks_len"}, ks_q.size(), 64 * n);
    mism = 0;
    for (int i = 0; i < 64 * n; i++)
      if (i >= ks_q.size() || ks_q[i] != int'(core_byte(core_mode, core_seed, i / 64, i % 64)))
        mism++;
    check({tag, " ks_data_mismatches"}, mism, 0);
    mism = 0;
    for (int i = 0; i < ks_q.size(); i++)
      if (i / 64 >= rd_cyc_q.size() || ks_cyc_q[i] != rd_cyc_q[i / 64] + 2 + i % 64) mism++;
    check({tag, " ks_timing_mismatches"}, mism, 0);
    check({tag, " ks_last_count"}, last_cnt, 1);
    check({tag, " ks_last_index"}, last_idx, 64 * n - 1);
    check({tag, " ctr_wrap_count"}, wrap_cnt, exp_wraps);
    check({tag, " cfg_handshakes"}, hs_cnt, 48);
    check({tag, " wr_key_count"}, key_cnt, 1);
    check({tag, " key_latency"}, key_cyc - last_hs_cyc, 1);
    check({tag, " nnc_offset"}, nnc_cyc - key_cyc, 32);
    check({tag, " ctr_offset"}, ctr_cyc - key_cyc, 44);
    check({tag, " protocol_violations"}, viol, 0);
    $display("[TB] run %s n=%0d ctr=%08h writes=%0d ks=%0d wraps=%0d errors=%0d",
             tag, n, ctr0, wr_q.size(), ks_q.size(), wrap_cnt, fails - f0);
  endtask

  task automatic do_run(input string tag, input int n, input int gap, input int delay,
                        input int mode, input int exp_wraps);
    ready_delay = delay;
    core_mode = mode;
    core_seed = $urandom;
    clear_mon();
    // cfg_valid while idle must not be accepted
    cfg_valid = 1'b1;
    cfg_data = 8'hEE;
    repeat (3) tick();
    cfg_valid = 1'b0;
    pulse_start(8'(n));
    feed(0, 48, gap);
    pulse_start(8'd9);  // start while busy: must be ignored
    wait_idle();
    compare(tag, n, exp_wraps);
  endtask

  task automatic set_cfg(input int fixed_key, input logic [31:0] ctr);
    for (int i = 0; i < 44; i++) cfg_bytes[i] = (fixed_key != 0) ? 8'(i) : 8'($urandom);
    for (int j = 0; j < 4; j++) cfg_bytes[44 + j] = ctr[8*j +: 8];
  endtask

  typedef struct {
    int          n;
    logic [31:0] ctr;
    int          gap;
    int          delay;
    int          mode;
    int          fixed_key;
    int          exp_wraps;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   w, n, wr;
    logic [31:0] ctr;
    vecs[0] = '{n: 1, ctr: 32'h0000_0001, gap: 1, delay: 3,   mode: 0, fixed_key: 1, exp_wraps: 0};
    vecs[1] = '{n: 3, ctr: 32'h0000_0005, gap: 0, delay: 2,   mode: 1, fixed_key: 0, exp_wraps: 0};
    vecs[2] = '{n: 2, ctr: 32'hFFFF_FFFF, gap: 0, delay: 1,   mode: 1, fixed_key: 0, exp_wraps: 1};
    vecs[3] = '{n: 1, ctr: 32'h1234_5678, gap: 1, delay: 100, mode: 1, fixed_key: 0, exp_wraps: 0};
    vecs[4] = '{n: 4, ctr: 32'hFFFF_FFFE, gap: 1, delay: 7,   mode: 1, fixed_key: 0, exp_wraps: 1};

    rst_n = 1'b0;
    start = 1'b0;
    blk_count = 8'd0;
    cfg_valid = 1'b0;
    cfg_data = 8'd0;
    repeat (3) tick();
    check("reset_outputs",
          longint'({busy, cfg_ready, ks_valid, ks_data, ks_last, ctr_wrap,
                    cc_wr_key, cc_wr_nnc, cc_wr_ctr, cc_din, cc_rd_blk}), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();

    // blk_count == 0 start is ignored
    pulse_start(8'd0);
    repeat (5) tick();
    check("zero_count_busy", longint'(busy), 0);
    check("zero_count_cfg_ready", longint'(cfg_ready), 0);

    // Directed table
    for (int v = 0; v < 5; v++) begin
      set_cfg(vecs[v].fixed_key, vecs[v].ctr);
      do_run($sformatf("vec%0d", v), vecs[v].n, vecs[v].gap, vecs[v].delay,
             vecs[v].mode, vecs[v].exp_wraps);
    end

    // Randomised runs against the reference model
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 4);
      ctr = (r % 2 == 0) ? 32'($urandom) : 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      wr = 0;
      for (int b = 1; b < n; b++) if (ctr + 32'(b) == 32'd0) wr++;
      set_cfg(0, ctr);
      do_run($sformatf("rnd%0d", r), n, $urandom_range(0, 1), $urandom_range(1, 15), 1, wr);
    end

    // Reset in the middle of the key burst
    set_cfg(0, 32'h0000_0010);
    cfg_bytes[0] = 8'h5A;
    cfg_bytes[5] = 8'hA5;
    ready_delay = 2;
    core_mode = 1;
    core_seed = $urandom;
    clear_mon();
    pulse_start(8'd1);
    feed(0, 48, 0);
    w = 0;
    while (!cc_wr_key && w < 300) begin
      tick();
      w++;
    end
    check("rst_wr_key_seen", longint'(cc_wr_key), 1);
    repeat (5) tick();
    check("rst_din_mid_burst", longint'(cc_din), 8'hA5);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", longint'({cc_wr_key, cc_din, busy, ks_valid, cfg_ready}), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    clear_mon();
    pulse_start(8'd1);
    feed(0, 47, 0);
    repeat (40) tick();
    check("rst_no_key_before_full_load", key_cnt, 0);
    check("rst_still_loading", longint'(cfg_ready), 1);
    feed(47, 48, 0);
    wait_idle();
    compare("reset_reload", 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
